// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - shared types and constants for the UART transmit arbiter
package uart_arb_pkg;

  localparam int BYTE_W                 = 8;
  localparam int DEFAULT_TIMEOUT_CYCLES = 64;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - producer/transmitter bundle seen by the UART transmit arbiter
interface uart_tx_arbiter_if
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
);

  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*BYTE_W-1:0] req_data;
  logic [NUM_REQ-1:0]        ack;
  logic                      tx_start;
  logic [BYTE_W-1:0]         to_tx;
  logic                      busy;
  logic [ID_W-1:0]           grant_id;
  logic                      active;
  logic                      timeout_err;

  modport master (
    output req, req_data, busy,
    input  ack, tx_start, to_tx, grant_id, active, timeout_err
  );

  modport slave (
    input  req, req_data, busy,
    output ack, tx_start, to_tx, grant_id, active, timeout_err
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_picker.sv
// rtl/uart_tx_arbiter_rr_picker.sv - combinational round-robin winner search starting after the last grant
module rr_picker #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last,
  output logic               valid,
  output logic [ID_W-1:0]    winner
);

  always_comb begin
    int idx;
    idx    = 0;
    valid  = 1'b0;
    winner = '0;
    // Offset 1..NUM_REQ so the last winner is checked last.
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(last) + i) % NUM_REQ;
      if (!valid && req[idx]) begin
        valid  = 1'b1;
        winner = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin sharing of one UART transmitter among NUM_REQ byte producers
// Optional busy-rise timeout enabled by UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_arbiter_if.slave  bus
);

  localparam int ID_W = $clog2(NUM_REQ);

  arb_state_e        state, state_nxt;
  logic [ID_W-1:0]   last;
  logic [ID_W-1:0]   grant_id_q;
  logic [BYTE_W-1:0] to_tx_q;
  logic              pick_valid;
  logic [ID_W-1:0]   pick_id;
  logic              grant;
  logic              timeout_hit;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_picker (
    .req    (bus.req),
    .last   (last),
    .valid  (pick_valid),
    .winner (pick_id)
  );

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] to_cnt;
  logic             err_q;

  assign timeout_hit = (state == WAIT_BUSY) && !bus.busy &&
                       (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      to_cnt <= (state == WAIT_BUSY) ? to_cnt + 1'b1 : '0;
      if (timeout_hit)
        err_q <= 1'b1;
    end
  end

  assign bus.timeout_err = err_q;
`else
  assign timeout_hit     = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    case (state)
      IDLE: begin
        // A busy transmitter blocks arbitration entirely; nothing is latched.
        if (pick_valid && !bus.busy) begin
          grant     = 1'b1;
          state_nxt = LAUNCH;
        end
      end
      LAUNCH:    state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (bus.busy)
          state_nxt = WAIT_DONE;
        else if (timeout_hit)
          state_nxt = IDLE;
      end
      WAIT_DONE: begin
        if (!bus.busy)
          state_nxt = IDLE;
      end
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last       <= ID_W'(NUM_REQ - 1);
      grant_id_q <= '0;
      to_tx_q    <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        last       <= pick_id;
        grant_id_q <= pick_id;
        to_tx_q    <= bus.req_data[int'(pick_id)*BYTE_W +: BYTE_W];
      end
    end
  end

  assign bus.tx_start = (state == LAUNCH);
  assign bus.ack      = (state == LAUNCH) ? (NUM_REQ'(1) << grant_id_q) : '0;
  assign bus.to_tx    = to_tx_q;
  assign bus.grant_id = grant_id_q;
  assign bus.active   = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(2)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ        (2),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [1:0]  req;
    logic [15:0] data;
    logic [1:0]  ack;
    logic [7:0]  to_tx;
    logic        gid;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic wait_launch(input string name);
    int n;
    n = 0;
    while (bus.tx_start !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_launch_seen"}, 32'(bus.tx_start), 1);
  endtask

  // Called at the negedge inside LAUNCH; returns at the first negedge back in IDLE.
  task automatic finish_xfer();
    @(negedge clk);
    @(negedge clk);
    bus.busy = 1'b1;
    repeat (3) @(negedge clk);
    bus.busy = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{req: 2'b11, data: 16'h5AA5, ack: 2'b01, to_tx: 8'hA5, gid: 1'b0};
    vecs[1] = '{req: 2'b10, data: 16'h5AA5, ack: 2'b10, to_tx: 8'h5A, gid: 1'b1};
    vecs[2] = '{req: 2'b01, data: 16'h0041, ack: 2'b01, to_tx: 8'h41, gid: 1'b0};
    vecs[3] = '{req: 2'b01, data: 16'h00C3, ack: 2'b01, to_tx: 8'hC3, gid: 1'b0};
    vecs[4] = '{req: 2'b10, data: 16'h7E00, ack: 2'b10, to_tx: 8'h7E, gid: 1'b1};
    vecs[5] = '{req: 2'b11, data: 16'h2211, ack: 2'b01, to_tx: 8'h11, gid: 1'b0};
    vecs[6] = '{req: 2'b11, data: 16'h4433, ack: 2'b10, to_tx: 8'h44, gid: 1'b1};

    bus.req      = '0;
    bus.req_data = '0;
    bus.busy     = 1'b0;

    @(negedge clk);
    chk("rst_tx_start", 32'(bus.tx_start), 0);
    chk("rst_ack", 32'(bus.ack), 0);
    chk("rst_to_tx", 32'(bus.to_tx), 0);
    chk("rst_grant_id", 32'(bus.grant_id), 0);
    chk("rst_active", 32'(bus.active), 0);
    chk("rst_timeout_err", 32'(bus.timeout_err), 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      bus.req      = vecs[i].req;
      bus.req_data = vecs[i].data;
      chk($sformatf("v%0d_idle_no_start", i), 32'(bus.tx_start), 0);
      @(negedge clk);
      chk($sformatf("v%0d_tx_start", i), 32'(bus.tx_start), 1);
      chk($sformatf("v%0d_ack", i), 32'(bus.ack), 32'(vecs[i].ack));
      chk($sformatf("v%0d_to_tx", i), 32'(bus.to_tx), 32'(vecs[i].to_tx));
      chk($sformatf("v%0d_grant_id", i), 32'(bus.grant_id), 32'(vecs[i].gid));
      bus.req = '0;
      @(negedge clk);
      chk($sformatf("v%0d_start_one_cycle", i), 32'(bus.tx_start), 0);
      chk($sformatf("v%0d_ack_one_cycle", i), 32'(bus.ack), 0);
      @(negedge clk);
      bus.busy = 1'b1;
      repeat (3) @(negedge clk);
      chk($sformatf("v%0d_active_busy", i), 32'(bus.active), 1);
      bus.busy = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d_active_done", i), 32'(bus.active), 0);
      chk($sformatf("v%0d_to_tx_held", i), 32'(bus.to_tx), 32'(vecs[i].to_tx));
    end

    // Busy blocking: requester 1 waits while the transmitter is busy.
    bus.busy     = 1'b1;
    bus.req      = 2'b10;
    bus.req_data = 16'h9900;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("blk%0d_no_start", k), 32'(bus.tx_start), 0);
      chk($sformatf("blk%0d_no_ack", k), 32'(bus.ack), 0);
      chk($sformatf("blk%0d_idle", k), 32'(bus.active), 0);
    end
    bus.busy = 1'b0;
    @(negedge clk);
    chk("blk_release_start", 32'(bus.tx_start), 1);
    chk("blk_release_ack", 32'(bus.ack), 2'b10);
    chk("blk_release_to_tx", 32'(bus.to_tx), 8'h99);
    bus.req = '0;
    finish_xfer();

    // Fairness: both held high across six transfers.
    bus.req      = 2'b11;
    bus.req_data = 16'hBBAA;
    for (int k = 0; k < 6; k++) begin
      wait_launch($sformatf("fair%0d", k));
      chk($sformatf("fair%0d_grant_id", k), 32'(bus.grant_id), 32'(k % 2));
      chk($sformatf("fair%0d_ack", k), 32'(bus.ack), 32'(1 << (k % 2)));
      if (k == 5) bus.req = '0;
      finish_xfer();
    end
    chk("fair_quiet_after", 32'(bus.active), 0);

    // Reset asserted in WAIT_DONE.
    bus.req      = 2'b01;
    bus.req_data = 16'h005C;
    @(negedge clk);
    chk("rstmid_launch", 32'(bus.tx_start), 1);
    bus.req = '0;
    @(negedge clk);
    bus.busy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rstmid_in_done", 32'(bus.active), 1);
    #2 rst = 1'b1;
    #1;
    chk("rstmid_active", 32'(bus.active), 0);
    chk("rstmid_to_tx", 32'(bus.to_tx), 0);
    chk("rstmid_ack", 32'(bus.ack), 0);
    chk("rstmid_tx_start", 32'(bus.tx_start), 0);
    @(negedge clk);
    chk("rstmid_no_ack_held", 32'(bus.ack), 0);
    rst      = 1'b0;
    bus.busy = 1'b0;
    bus.req      = 2'b10;
    bus.req_data = 16'h6600;
    @(negedge clk);
    chk("post_rst_ack", 32'(bus.ack), 2'b10);
    chk("post_rst_to_tx", 32'(bus.to_tx), 8'h66);
    bus.req = '0;
    finish_xfer();
    bus.req      = 2'b11;
    bus.req_data = 16'h7788;
    @(negedge clk);
    chk("post_rst_pref_ack", 32'(bus.ack), 2'b01);
    chk("post_rst_pref_to_tx", 32'(bus.to_tx), 8'h88);
    bus.req = '0;
    finish_xfer();

    // Busy never rises after tx_start.
    bus.req      = 2'b01;
    bus.req_data = 16'h00E1;
    @(negedge clk);
    chk("to_launch", 32'(bus.tx_start), 1);
    bus.req = '0;
`ifdef UART_ARB_TIMEOUT_EN
    begin
      int cyc;
      cyc = 0;
      @(negedge clk);
      while (bus.active === 1'b1 && cyc < 200) begin
        cyc++;
        @(negedge clk);
      end
      chk("to_wait_cycles", 32'(cyc), 64);
      chk("to_err_set", 32'(bus.timeout_err), 1);
    end
    bus.req      = 2'b10;
    bus.req_data = 16'h3C00;
    @(negedge clk);
    chk("to_next_ack", 32'(bus.ack), 2'b10);
    chk("to_next_to_tx", 32'(bus.to_tx), 8'h3C);
    bus.req = '0;
    finish_xfer();
    chk("to_err_sticky", 32'(bus.timeout_err), 1);
`else
    repeat (100) @(negedge clk);
    chk("to_still_waiting", 32'(bus.active), 1);
    chk("to_err_zero", 32'(bus.timeout_err), 0);
    bus.busy = 1'b1;
    repeat (2) @(negedge clk);
    bus.busy = 1'b0;
    @(negedge clk);
    chk("to_done_idle", 32'(bus.active), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter (UART_Tx_fsm) between NUM_REQ byte producers, e.g. RX echo path and LED/status reporter.
- Round-robin arbitration; owns the transmitter's tx_start/to_tx inputs and tracks its busy output.
- Sits between the producers and UART_Tx_fsm in UART_top, in the clk_wiz_out domain.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- TIMEOUT_CYCLES, 64, max cycles to wait for busy to rise after tx_start (used only with UART_ARB_TIMEOUT_EN).

Ports:
- clk  input  1  system clock (clk_wiz_out).
- rst  input  1  asynchronous, active-high reset.
- req  input  NUM_REQ  per-requester byte request; held with data until ack.
- req_data  input  NUM_REQ*8  byte i occupies bits [8i+7:8i].
- ack  output  NUM_REQ  one-cycle pulse; byte from requester i launched.
- tx_start  output  1  one-cycle start pulse to UART_Tx_fsm.
- to_tx  output  8  registered byte to UART_Tx_fsm.
- busy  input  1  busy from UART_Tx_fsm.
- grant_id  output  $clog2(NUM_REQ)  index of last/current granted requester.
- active  output  1  high while state != IDLE.
- timeout_err  output  1  sticky error flag; constant 0 when UART_ARB_TIMEOUT_EN is undefined.

Behaviour:
- Reset values: state IDLE; tx_start 0; to_tx 8'h00; ack 0; grant_id 0; active 0; timeout_err 0; rr pointer last=NUM_REQ-1, so requester 0 has first priority.
- States:
  - IDLE: if |req and busy==0, pick winner = first set req searching from last+1 with wrap. Latch req_data[winner] into to_tx, set grant_id, update last, go to LAUNCH. If busy==1, stay in IDLE and grant nothing.
  - LAUNCH: exactly one cycle. tx_start=1 and ack[winner]=1 together. Next state is WAIT_BUSY.
  - WAIT_BUSY: stay until busy==1, then go to WAIT_DONE.
  - WAIT_DONE: stay until busy==0, then go to IDLE.
- Latency: req seen in IDLE at cycle N gives tx_start/ack at N+1. Back-to-back bytes need at least one IDLE cycle between them.
- to_tx is held stable from LAUNCH until the next grant.
- Requester rules:
  - Keep req and data stable until ack.
  - req dropped after the winner is latched in IDLE: the latched byte is still sent and ack still pulses.
  - req kept high after ack means a new byte; it is served again only after the other pending requesters, per round-robin.
- Simultaneous requests: exactly one grant per arbitration cycle; the rest wait.
- Async reset mid-transfer (any state): immediate return to reset values; no ack for the aborted byte.
- ack and tx_start are never high outside LAUNCH.

Optional Feature:
- Macro: UART_ARB_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT_BUSY.
  - If busy is still 0 after TIMEOUT_CYCLES cycles, go to IDLE and set timeout_err=1.
  - timeout_err clears only on rst.
- Undefined: no counter; WAIT_BUSY waits indefinitely; timeout_err tied to 0.

Decomposition:
- Package uart_arb_pkg:
  - state enum IDLE/LAUNCH/WAIT_BUSY/WAIT_DONE (2-bit);
  - BYTE_W=8;
  - default TIMEOUT_CYCLES.
- Sub-module rr_picker (combinational):
  - inputs req vector and last index;
  - outputs valid and winner index with wrap-around search.
- The FSM, data latch and timeout counter stay in uart_tx_arbiter.

Test Plan:
- Single request: req=01, data0=8'h41, busy model rises 2 cycles after tx_start and stays high 20 cycles. Expect: tx_start and ack=01 one cycle after req, to_tx=8'h41, active low again after busy falls.
- Simultaneous: req=11, data0=8'hA5, data1=8'h5A. Expect: first to_tx=A5 with ack=01, second to_tx=5A with ack=10.
- Fairness: req=11 held continuously for 6 transfers. Expect: grant_id sequence 0,1,0,1,0,1 and no consecutive repeats.
- Busy blocking: busy forced 1 while idle and req=01. Expect: no tx_start and no ack until busy=0, then a launch the next cycle.
- Reset mid-transfer: assert rst during WAIT_DONE. Expect: all outputs at reset values immediately. After release, req=10 is granted, and requester 0 is preferred if both requesters request.
- With UART_ARB_TIMEOUT_EN: busy held 0 after tx_start. Expect: return to IDLE after 64 cycles with timeout_err=1. A following request still launches normally.
